// File: rtl/decode_hazard_ctrl.sv
// Pipeline sequencing controller beside the decode stage: tracks in-flight
// register writes, detects RAW hazards for the instruction in ID, freezes on
// data-memory busy, flushes wrong-path work on taken branches and drains the
// pipe on HALT.
module decode_hazard_ctrl #(
  parameter int SB_ISSUE_CNT = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_use,
  input  logic        id_rt_use,
  input  logic [2:0]  id_rd,
  input  logic        id_regwrt,
  input  logic        id_halt,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        id_nop,
  output logic        issue,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        pipe_freeze,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sb [8];
  logic [7:0]  drain_q, drain_d;
  logic        adv;
  logic        raw;
  logic        rs_busy, rt_busy;
  logic        stall_now;

  // The pipe only moves when data memory is not holding it up.
  assign adv = ~mem_busy;

  // A source is hazardous while its scoreboard entry has not counted down.
  assign rs_busy = id_rs_use && (sb[id_rs] != 2'd0);
  assign rt_busy = id_rt_use && (sb[id_rt] != 2'd0);
  assign raw     = id_valid && (rs_busy || rt_busy);

  assign state = state_q;

  // Cycles charged to stalls: memory freezes and RAW stalls a flush does not override.
  assign stall_now = (state_q == RUN) && (mem_busy || (raw && !br_taken));

  // Control outputs and next state, all decided within the current cycle.
  always_comb begin
    id_nop      = 1'b0;
    issue       = 1'b0;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;
    if (!rst) begin
      id_nop    = 1'b1;
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            pipe_freeze = 1'b1;
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
          end else if (br_taken) begin
            ifid_flush = 1'b1;
            id_nop     = 1'b1;
          end else if (raw) begin
            id_nop    = 1'b1;
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
          end else begin
            issue = id_valid;
          end
          if (issue && id_halt) begin
            state_d = DRAIN;
            drain_d = 8'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          id_nop      = 1'b1;
          pipe_freeze = mem_busy;
          if (adv) begin
            if (drain_q <= 8'd1) begin
              drain_d = 8'd0;
              state_d = HALTED;
            end else begin
              drain_d = drain_q - 8'd1;
            end
          end
        end
        HALTED: begin
          halted    = 1'b1;
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          id_nop    = 1'b1;
        end
        default: begin
          id_nop    = 1'b1;
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          state_d   = RUN;
        end
      endcase
    end
  end

  // State, drain counter and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      drain_q   <= 8'd0;
      stall_cnt <= 16'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_now && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  // Scoreboard: issuing writers load their entry, others count down while the pipe advances.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        sb[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (issue && id_regwrt && (id_rd == 3'(i))) begin
          sb[i] <= 2'(SB_ISSUE_CNT);
        end else if (adv && (sb[i] != 2'd0)) begin
          sb[i] <= sb[i] - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed testbench for decode_hazard_ctrl with hand-computed expectations.
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        id_rs_use, id_rt_use, id_regwrt, id_halt;
  logic        br_taken, mem_busy;
  logic        id_nop, issue, pc_hold, ifid_hold, ifid_flush, pipe_freeze, halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stall;

  decode_hazard_ctrl #(.SB_ISSUE_CNT(2), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_rd(id_rd),
    .id_regwrt(id_regwrt), .id_halt(id_halt), .br_taken(br_taken),
    .mem_busy(mem_busy), .id_nop(id_nop), .issue(issue), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .pipe_freeze(pipe_freeze),
    .halted(halted), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_use = 0; id_rt_use = 0; id_regwrt = 0; id_halt = 0;
    br_taken = 0; mem_busy = 0;
  endtask

  task automatic writer(input logic [2:0] rd);
    idle();
    id_valid = 1; id_regwrt = 1; id_rd = rd;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick();
    rst = 1;
    exp_stall = 16'd0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    tick();
    for (int c = 0; c < 2; c++) begin
      id_valid = 1'($urandom); id_rs = 3'($urandom); id_rt = 3'($urandom);
      id_rd = 3'($urandom); id_rs_use = 1'($urandom); id_rt_use = 1'($urandom);
      id_regwrt = 1'($urandom); id_halt = 1'($urandom);
      br_taken = 1'($urandom); mem_busy = 1'($urandom);
      #1;
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL rst_issue: got %b want 0", issue); end
      checks++; if (id_nop !== 1'b1) begin errors++; $display("FAIL rst_id_nop: got %b want 1", id_nop); end
      checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL rst_pc_hold: got %b want 1", pc_hold); end
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state: got %b want 00", state); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %h want 0000", stall_cnt); end
      tick();
    end
    idle();
    rst = 1;
    exp_stall = 16'd0;
    id_valid = 1; id_rs = 3'd1; id_rs_use = 1;
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL rst_release_issue: got %b want 1", issue); end
    tick();
    idle();
  endtask

  task automatic test_raw();
    writer(3'd3);
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_writer_issue: got %b want 1", issue); end
    tick();
    idle(); id_valid = 1; id_rs = 3'd3; id_rs_use = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (id_nop !== 1'b1) begin errors++; $display("FAIL raw_id_nop[%0d]: got %b want 1", c, id_nop); end
      checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL raw_pc_hold[%0d]: got %b want 1", c, pc_hold); end
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL raw_issue_blocked[%0d]: got %b want 0", c, issue); end
      tick();
      exp_stall = exp_stall + 16'd1;
    end
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_issue_third: got %b want 1", issue); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    tick();
    // Unused rt source must not stall.
    writer(3'd3);
    tick();
    idle(); id_valid = 1; id_rt = 3'd3; id_rt_use = 0; id_rs = 3'd0; id_rs_use = 1;
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_rt_unused_issue: got %b want 1", issue); end
    tick();
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL raw_rt_unused_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    idle();
    tick(); tick();
  endtask

  task automatic test_freeze();
    writer(3'd3);
    tick();
    idle(); id_valid = 1; id_rs = 3'd3; id_rs_use = 1;
    tick();
    exp_stall = exp_stall + 16'd1;
    mem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (pipe_freeze !== 1'b1) begin errors++; $display("FAIL frz_pipe_freeze[%0d]: got %b want 1", c, pipe_freeze); end
      checks++; if (id_nop !== 1'b0) begin errors++; $display("FAIL frz_id_nop[%0d]: got %b want 0", c, id_nop); end
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL frz_issue[%0d]: got %b want 0", c, issue); end
      tick();
      exp_stall = exp_stall + 16'd1;
    end
    mem_busy = 0;
    #1;
    checks++; if (id_nop !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL frz_raw_after: got nop=%b issue=%b want nop=1 issue=0", id_nop, issue); end
    checks++; if (pipe_freeze !== 1'b0) begin errors++; $display("FAIL frz_released: got %b want 0", pipe_freeze); end
    tick();
    exp_stall = exp_stall + 16'd1;
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL frz_issue_final: got %b want 1", issue); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL frz_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    tick();
    idle();
  endtask

  task automatic test_flush();
    writer(3'd3);
    tick();
    idle(); id_valid = 1; id_rs = 3'd3; id_rs_use = 1; br_taken = 1;
    #1;
    checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL flush_flush: got %b want 1", ifid_flush); end
    checks++; if (id_nop !== 1'b1) begin errors++; $display("FAIL flush_id_nop: got %b want 1", id_nop); end
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL flush_pc_hold: got %b want 0", pc_hold); end
    tick();
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    mem_busy = 1;
    #1;
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL flush_busy_noflush: got %b want 0", ifid_flush); end
    checks++; if (pipe_freeze !== 1'b1) begin errors++; $display("FAIL flush_busy_freeze: got %b want 1", pipe_freeze); end
    tick();
    exp_stall = exp_stall + 16'd1;
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL flush_busy_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    idle();
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    writer(3'd5);
    tick();
    writer(3'd5);
    tick();
    idle(); id_valid = 1; id_rs = 3'd5; id_rs_use = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL b2b_blocked[%0d]: got %b want 0", c, issue); end
      tick();
      exp_stall = exp_stall + 16'd1;
    end
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL b2b_issue: got %b want 1", issue); end
    tick();
    // R0 is tracked like any other register.
    writer(3'd0);
    tick();
    idle(); id_valid = 1; id_rt = 3'd0; id_rt_use = 1;
    #1;
    checks++; if (id_nop !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL r0_stall: got nop=%b issue=%b want nop=1 issue=0", id_nop, issue); end
    tick(); tick();
    exp_stall = exp_stall + 16'd2;
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL b2b_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    idle();
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    idle(); id_valid = 1; id_halt = 1; br_taken = 1;
    #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL halt_br_issue: got %b want 0", issue); end
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL halt_br_state: got %b want 00", state); end
    idle(); id_valid = 1; id_halt = 1;
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL halt_issue: got %b want 1", issue); end
    tick();
    idle(); id_valid = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL halt_drain_state[%0d]: got %b want 01", c, state); end
      checks++; if (pc_hold !== 1'b1 || id_nop !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL halt_drain_ctl[%0d]: got hold=%b nop=%b issue=%b want 1 1 0", c, pc_hold, id_nop, issue); end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      checks++; if (state !== 2'b10) begin errors++; $display("FAIL halt_state[%0d]: got %b want 10", c, state); end
      checks++; if (halted !== 1'b1 || pc_hold !== 1'b1) begin errors++; $display("FAIL halt_halted[%0d]: got halted=%b hold=%b want 1 1", c, halted, pc_hold); end
      tick();
    end
    // Second run: two busy cycles stretch the drain to five cycles.
    do_reset();
    idle(); id_valid = 1; id_halt = 1;
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      mem_busy = (c == 1 || c == 2);
      #1;
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL halt2_drain_state[%0d]: got %b want 01", c, state); end
      if (c == 1) begin
        checks++; if (pipe_freeze !== 1'b1) begin errors++; $display("FAIL halt2_freeze: got %b want 1", pipe_freeze); end
      end
      tick();
    end
    idle();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL halt2_state: got %b want 10", state); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL halt2_no_count: got %0d want 0", stall_cnt); end
    // Reset mid-drain returns to RUN.
    do_reset();
    idle(); id_valid = 1; id_halt = 1;
    tick();
    idle();
    do_reset();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL halt_reset_mid_drain: got %b want 00", state); end
  endtask

  task automatic test_saturation();
    do_reset();
    idle(); mem_busy = 1;
    repeat (65534) tick();
    checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h want fffe", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold1: got %h want ffff", stall_cnt); end
    repeat (3) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold2: got %h want ffff", stall_cnt); end
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    exp_stall = 16'd0;
    test_reset();
    test_raw();
    test_freeze();
    test_flush();
    test_back_to_back();
    test_halt();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
